// File: rtl/serial_alu_seq_if.sv
// serial_alu_seq_if
//   Bundles the request and result sides of the bit-serial ALU sequencer.
//
//   Handshake rule, used on both channels: a transfer happens on a rising
//   clock edge where valid && ready are both high. The producer holds valid
//   and its payload until that edge. The consumer may drive ready freely.
//
//   Request channel (producer = requester, consumer = sequencer):
//     start_valid, start_ready, x_in, y_in, sub_in, cin_in, cen_in
//   Result channel (producer = sequencer, consumer = requester):
//     done_valid, done_ready, result_out, carry_out, zero_out, ovf_out
//
//   Modports:
//     master - the requester / result consumer
//     slave  - the sequencer
interface serial_alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic             sub_in;
    logic             cin_in;
    logic [3:0]       cen_in;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] result_out;
    logic             carry_out;
    logic             zero_out;
    logic             ovf_out;

    modport master (
        output start_valid, x_in, y_in, sub_in, cin_in, cen_in, done_ready,
        input  start_ready, done_valid, result_out, carry_out, zero_out, ovf_out
    );

    modport slave (
        input  start_valid, x_in, y_in, sub_in, cin_in, cen_in, done_ready,
        output start_ready, done_valid, result_out, carry_out, zero_out, ovf_out
    );
endinterface

// File: rtl/serial_alu_seq.sv
// serial_alu_seq
//   Bit-serial operand sequencer wrapped around an external 1-bit adder
//   slice. It accepts two WIDTH-bit operands, streams them LSB first into
//   the slice with the running carry, reassembles the sum bits into a
//   WIDTH-bit result and offers result plus flags on a valid/ready channel.
//
//   Parameters:
//     WIDTH - operand/result width (>= 2)
//     CNT_W - bit counter width (2**CNT_W > WIDTH)
//
//   Ports:
//     clk, rst            - clock, synchronous active-high reset
//     bus (slave)         - request and result channels (see serial_alu_seq_if)
//     x_bit, y_bit, c_bit - bit pair and carry-in for the slice (0 outside SHIFT)
//     c_en                - carry-enable field captured at accept
//     sum_bit, carry_bit  - slice outputs for the current bit
//     state_dbg           - current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
//   Optional feature: define SERIAL_ALU_OVF_EN to generate the signed
//   overflow flag; otherwise ovf_out is tied to 0.
module serial_alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    serial_alu_seq_if.slave     bus,
    output logic                x_bit,
    output logic                y_bit,
    output logic                c_bit,
    output logic [3:0]          c_en,
    input  logic                sum_bit,
    input  logic                carry_bit,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] x_sh, y_sh, res_q, res_next;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cen_q;
    logic             cout_q, zero_q;
    logic             accept, last_bit, start_ready, done_valid;

    // Sum bits enter at the MSB; after WIDTH shifts the first sum is at bit 0.
    assign res_next = {sum_bit, res_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        x_bit       = 1'b0;
        y_bit       = 1'b0;
        c_bit       = 1'b0;
        accept      = 1'b0;
        last_bit    = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (bus.start_valid) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                x_bit    = x_sh[0];
                y_bit    = y_sh[0];
                c_bit    = carry_q;
                last_bit = (cnt == CNT_W'(WIDTH - 1));
                if (last_bit) state_nx = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                if (bus.done_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_sh    <= '0;
            y_sh    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            cen_q   <= 4'b0000;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            x_sh    <= bus.x_in;
            y_sh    <= bus.sub_in ? ~bus.y_in : bus.y_in;
            // Subtraction is X + ~Y + 1, so the initial carry is forced high.
            carry_q <= bus.sub_in | bus.cin_in;
            cen_q   <= bus.cen_in;
            cnt     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else if (state == SHIFT) begin
            res_q   <= res_next;
            carry_q <= carry_bit;
            x_sh    <= x_sh >> 1;
            y_sh    <= y_sh >> 1;
            cnt     <= cnt + CNT_W'(1);
            if (last_bit) begin
                cout_q <= carry_bit;
                zero_q <= (res_next == '0);
            end
        end
    end

`ifdef SERIAL_ALU_OVF_EN
    logic ovf_q;
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst || accept) ovf_q <= 1'b0;
        else if (last_bit) ovf_q <= carry_q ^ carry_bit;
    end
    assign bus.ovf_out = ovf_q;
`else
    assign bus.ovf_out = 1'b0;
`endif

    assign bus.start_ready = start_ready;
    assign bus.done_valid  = done_valid;
    assign bus.result_out  = res_q;
    assign bus.carry_out   = cout_q;
    assign bus.zero_out    = zero_q;
    assign c_en            = cen_q;
    assign state_dbg       = state;

endmodule

// File: tb/tb_serial_alu_seq.sv
module tb_serial_alu_seq;

    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       x_bit, y_bit, c_bit, sum_bit, carry_bit;
    logic [3:0] c_en;
    logic [1:0] state_dbg;

    serial_alu_seq_if #(.WIDTH(W)) bus ();

    serial_alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .x_bit     (x_bit),
        .y_bit     (y_bit),
        .c_bit     (c_bit),
        .c_en      (c_en),
        .sum_bit   (sum_bit),
        .carry_bit (carry_bit),
        .state_dbg (state_dbg)
    );

    // Behavioural full-adder slice.
    assign {carry_bit, sum_bit} = 2'(x_bit) + 2'(y_bit) + 2'(c_bit);

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Observations gathered by collect().
    logic [W-1:0] got_res, got_xbits, got_ybits;
    logic         got_cout, got_zero, got_ovf, got_first_c;
    logic [3:0]   cen_and, cen_or;
    int           got_cycles;

    logic [W-1:0] exp_q[$];

    // Reference: whole-word arithmetic on the operands.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic sub, input logic cin,
                                  output logic [W-1:0] r, output logic c,
                                  output logic z, output logic o);
        logic [W:0]   s;
        logic [W-1:0] yy;
        yy = sub ? ~y : y;
        s  = {1'b0, x} + {1'b0, yy} + ((sub | cin) ? 33'd1 : 33'd0);
        r  = s[W-1:0];
        c  = s[W];
        z  = (r == 0);
`ifdef SERIAL_ALU_OVF_EN
        o  = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
`else
        o  = 1'b0;
`endif
    endfunction

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic sub, input logic cin, input logic [3:0] cen);
        int n;
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.x_in = x; bus.y_in = y; bus.sub_in = sub; bus.cin_in = cin; bus.cen_in = cen;
        n = 0;
        while (!bus.start_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
    endtask

    // Called right after the accept edge; scrambles inputs every cycle.
    task automatic collect();
        int k;
        k = 0;
        got_xbits = '0; got_ybits = '0; got_first_c = 1'b0;
        cen_and = 4'hF; cen_or = 4'h0;
        @(negedge clk);
        bus.start_valid = 1'b0;
        while (!bus.done_valid && k < 100) begin
            if (k < W) begin
                got_xbits[k] = x_bit;
                got_ybits[k] = y_bit;
            end
            if (k == 0) got_first_c = c_bit;
            cen_and &= c_en; cen_or |= c_en;
            bus.x_in = $urandom; bus.y_in = $urandom;
            bus.sub_in = 1'($urandom_range(0, 1)); bus.cin_in = 1'($urandom_range(0, 1));
            bus.cen_in = 4'($urandom_range(0, 15));
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        cen_and &= c_en; cen_or |= c_en;
        got_cycles = k;
        got_res = bus.result_out; got_cout = bus.carry_out;
        got_zero = bus.zero_out; got_ovf = bus.ovf_out;
    endtask

    task automatic finish_done();
        @(negedge clk);
        bus.done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.done_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_valid = 1'b0; bus.done_ready = 1'b0;
        bus.x_in = '0; bus.y_in = '0; bus.sub_in = 1'b0; bus.cin_in = 1'b0; bus.cen_in = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (bus.start_ready !== 1'b1) begin n_fail++; $display("FAIL reset start_ready: got %b want 1", bus.start_ready); end
        n_vec++; if (bus.done_valid !== 1'b0) begin n_fail++; $display("FAIL reset done_valid: got %b want 0", bus.done_valid); end
        n_vec++; if ({x_bit, y_bit, c_bit} !== 3'b000) begin n_fail++; $display("FAIL reset slice bits: got %b want 000", {x_bit, y_bit, c_bit}); end
        n_vec++; if (c_en !== 4'b0000) begin n_fail++; $display("FAIL reset c_en: got %b want 0000", c_en); end
        n_vec++; if (bus.result_out !== '0) begin n_fail++; $display("FAIL reset result: got %h want 0", bus.result_out); end
        n_vec++; if ({bus.carry_out, bus.zero_out, bus.ovf_out} !== 3'b000) begin n_fail++; $display("FAIL reset flags: got %b want 000", {bus.carry_out, bus.zero_out, bus.ovf_out}); end
        n_vec++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset state: got %0d want 0", state_dbg); end
    endtask

    task automatic test_add();
        logic [W-1:0] r; logic c, z, o;
        model(32'h5, 32'h3, 1'b0, 1'b0, r, c, z, o);
        start_op(32'h5, 32'h3, 1'b0, 1'b0, 4'b0000);
        collect();
        n_vec++; if (got_cycles !== 32) begin n_fail++; $display("FAIL add latency: got %0d want 32", got_cycles); end
        n_vec++; if (got_res !== r) begin n_fail++; $display("FAIL add result: got %h want %h", got_res, r); end
        n_vec++; if ({got_cout, got_zero} !== {c, z}) begin n_fail++; $display("FAIL add flags: got %b want %b", {got_cout, got_zero}, {c, z}); end
        n_vec++; if (got_first_c !== 1'b0) begin n_fail++; $display("FAIL add first c_bit: got %b want 0", got_first_c); end
        finish_done();
        n_vec++; if (bus.done_valid !== 1'b0) begin n_fail++; $display("FAIL add done_valid drop: got %b want 0", bus.done_valid); end
    endtask

    task automatic test_sub_zero();
        logic [W-1:0] r; logic c, z, o;
        model(32'hA, 32'hA, 1'b1, 1'b0, r, c, z, o);
        start_op(32'hA, 32'hA, 1'b1, 1'b0, 4'b0000);
        collect();
        n_vec++; if (got_first_c !== 1'b1) begin n_fail++; $display("FAIL sub first c_bit: got %b want 1", got_first_c); end
        n_vec++; if (got_ybits !== ~32'hA) begin n_fail++; $display("FAIL sub y_bits: got %h want %h", got_ybits, ~32'hA); end
        n_vec++; if (got_xbits !== 32'hA) begin n_fail++; $display("FAIL sub x_bits: got %h want %h", got_xbits, 32'hA); end
        n_vec++; if (got_res !== r) begin n_fail++; $display("FAIL sub result: got %h want %h", got_res, r); end
        n_vec++; if ({got_cout, got_zero} !== {c, z}) begin n_fail++; $display("FAIL sub flags: got %b want %b", {got_cout, got_zero}, {c, z}); end
        finish_done();
    endtask

    task automatic test_wrap();
        logic [W-1:0] xs[2];
        logic [W-1:0] r; logic c, z, o;
        xs[0] = 32'hFFFF_FFFF; xs[1] = 32'h7FFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            model(xs[i], 32'h1, 1'b0, 1'b0, r, c, z, o);
            start_op(xs[i], 32'h1, 1'b0, 1'b0, 4'b0000);
            collect();
            n_vec++; if (got_res !== r) begin n_fail++; $display("FAIL wrap%0d result: got %h want %h", i, got_res, r); end
            n_vec++; if ({got_cout, got_zero} !== {c, z}) begin n_fail++; $display("FAIL wrap%0d flags: got %b want %b", i, {got_cout, got_zero}, {c, z}); end
            n_vec++; if (got_ovf !== o) begin n_fail++; $display("FAIL wrap%0d ovf: got %b want %b", i, got_ovf, o); end
            finish_done();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, r, want; logic sub, cin, c, z, o;
        for (int i = 0; i < 20; i++) begin
            x = $urandom; y = $urandom;
            if (i % 5 == 0) y = x;
            sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            model(x, y, sub, cin, r, c, z, o);
            exp_q.push_back(r);
            start_op(x, y, sub, cin, 4'($urandom_range(0, 15)));
            collect();
            want = exp_q.pop_front();
            n_vec++; if (got_cycles !== 32) begin n_fail++; $display("FAIL rand%0d latency: got %0d want 32", i, got_cycles); end
            n_vec++; if (got_res !== want) begin n_fail++; $display("FAIL rand%0d result: got %h want %h", i, got_res, want); end
            n_vec++; if ({got_cout, got_zero, got_ovf} !== {c, z, o}) begin n_fail++; $display("FAIL rand%0d flags: got %b want %b", i, {got_cout, got_zero, got_ovf}, {c, z, o}); end
            n_vec++; if (got_xbits !== x) begin n_fail++; $display("FAIL rand%0d x_bits: got %h want %h", i, got_xbits, x); end
            n_vec++; if (got_ybits !== (sub ? ~y : y)) begin n_fail++; $display("FAIL rand%0d y_bits: got %h want %h", i, got_ybits, sub ? ~y : y); end
            finish_done();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ra, rb, xb, yb; logic c, z, o;
        model(32'h1234_5678, 32'h0000_1111, 1'b0, 1'b1, ra, c, z, o);
        start_op(32'h1234_5678, 32'h0000_1111, 1'b0, 1'b1, 4'b0101);
        collect();
        for (int i = 0; i < 10; i++) begin
            bus.start_valid = 1'(i % 2);
            bus.x_in = $urandom; bus.y_in = $urandom;
            n_vec++; if (bus.start_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d start_ready: got %b want 0", i, bus.start_ready); end
            n_vec++; if (bus.done_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d done_valid: got %b want 1", i, bus.done_valid); end
            n_vec++; if (bus.result_out !== ra) begin n_fail++; $display("FAIL bp%0d result: got %h want %h", i, bus.result_out, ra); end
            @(posedge clk);
            @(negedge clk);
        end
        xb = $urandom; yb = $urandom;
        model(xb, yb, 1'b1, 1'b0, rb, c, z, o);
        bus.start_valid = 1'b1; bus.done_ready = 1'b1;
        bus.x_in = xb; bus.y_in = yb; bus.sub_in = 1'b1; bus.cin_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.done_ready = 1'b0;
        n_vec++; if ({bus.done_valid, bus.start_ready} !== 2'b01) begin n_fail++; $display("FAIL bp release idle: got %b want 01", {bus.done_valid, bus.start_ready}); end
        @(posedge clk);
        collect();
        n_vec++; if (got_cycles !== 32) begin n_fail++; $display("FAIL bp pending latency: got %0d want 32", got_cycles); end
        n_vec++; if (got_res !== rb) begin n_fail++; $display("FAIL bp pending result: got %h want %h", got_res, rb); end
        finish_done();
    endtask

    task automatic test_reset_mid();
        logic seen;
        start_op(32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b0, 1'b1, 4'b1011);
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (bus.start_ready !== 1'b1) begin n_fail++; $display("FAIL midrst start_ready: got %b want 1", bus.start_ready); end
        n_vec++; if ({x_bit, y_bit, c_bit} !== 3'b000) begin n_fail++; $display("FAIL midrst slice bits: got %b want 000", {x_bit, y_bit, c_bit}); end
        n_vec++; if (c_en !== 4'b0000) begin n_fail++; $display("FAIL midrst c_en: got %b want 0000", c_en); end
        n_vec++; if (bus.result_out !== '0) begin n_fail++; $display("FAIL midrst result: got %h want 0", bus.result_out); end
        n_vec++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL midrst state: got %0d want 0", state_dbg); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= bus.done_valid;
        end
        n_vec++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst stray done_valid: got %b want 0", seen); end
    endtask

    task automatic test_cen_hold();
        start_op($urandom, $urandom, 1'b0, 1'b0, 4'b1011);
        collect();
        n_vec++; if (cen_and !== 4'b1011) begin n_fail++; $display("FAIL cen hold and: got %b want 1011", cen_and); end
        n_vec++; if (cen_or !== 4'b1011) begin n_fail++; $display("FAIL cen hold or: got %b want 1011", cen_or); end
        finish_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_zero();
        test_wrap();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_cen_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Bit-serial operand sequencer for the SimpleRISC ALU datapath. It sits directly upstream and downstream of the 1-bit adder slice.
- Accepts two WIDTH-bit operands plus an operation request. Streams one bit pair per cycle, LSB first, into the slice along with the running carry and the 4-bit carry-enable field.
- Collects the slice's sum and carry outputs back into a WIDTH-bit result, then presents the result and flags through a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (must be >= 2).
- CNT_W, 6, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  operation request valid.
- start_ready  output  1  high only in IDLE; a request is accepted when start_valid && start_ready.
- x_in  input  WIDTH  operand X.
- y_in  input  WIDTH  operand Y.
- sub_in  input  1  1 = subtract: Y is bit-inverted and the initial carry is forced to 1.
- cin_in  input  1  initial carry when sub_in = 0.
- cen_in  input  4  carry-enable field, captured at accept.
- x_bit  output  1  current X bit to the slice.
- y_bit  output  1  current Y bit to the slice (post-inversion).
- c_bit  output  1  carry into the slice for the current bit.
- c_en  output  4  captured carry-enable field, held stable for the whole operation.
- sum_bit  input  1  slice sum for the current bit.
- carry_bit  input  1  slice carry-out for the current bit.
- done_valid  output  1  result available.
- done_ready  input  1  consumer accepts the result.
- result_out  output  WIDTH  assembled result.
- carry_out  output  1  final carry (carry_bit of the MSB).
- zero_out  output  1  1 when result_out == 0.
- ovf_out  output  1  signed overflow (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE; start_ready = 1; done_valid = 0.
  - x_bit, y_bit, c_bit = 0; c_en = 4'b0000.
  - result_out = 0; carry_out = 0; zero_out = 0; ovf_out = 0; bit counter = 0.
- States:
  - IDLE:
    - On accept, load x_sh = x_in and y_sh = (sub_in ? ~y_in : y_in).
    - Load carry register = (sub_in ? 1 : cin_in).
    - Capture c_en = cen_in; clear counter and result register; go to SHIFT.
  - SHIFT:
    - Outputs are combinational from registers: x_bit = x_sh[0], y_bit = y_sh[0], c_bit = carry register.
    - Each cycle: capture sum_bit into the result register MSB, shifting right by 1.
    - Each cycle: carry register <= carry_bit; shift x_sh and y_sh right by 1; counter += 1.
    - On the cycle where counter == WIDTH-1, also latch carry_out <= carry_bit, then go to DONE.
  - DONE:
    - done_valid = 1. result_out, carry_out, zero_out and ovf_out are held stable.
    - On done_valid && done_ready, go to IDLE; done_valid falls the next cycle.
- Outside SHIFT, x_bit, y_bit and c_bit are driven 0; c_en keeps its last captured value.
- Latency: accept at edge 0; SHIFT occupies edges 1..WIDTH; done_valid is high after edge WIDTH. For WIDTH = 32 that is 32 cycles from accept to done_valid.
- Throughput: one operation per WIDTH+2 cycles minimum.
- zero_out is computed from the final assembled result when entering DONE.
- Boundary conditions:
  - start_valid while not IDLE: ignored, since start_ready = 0. Operands are not sampled.
  - done_ready held low: the block stalls in DONE indefinitely with outputs stable.
  - start_valid and done_ready both high in DONE: only the done handshake completes. The start is accepted no earlier than the following cycle, in IDLE.
  - rst asserted in any state, including mid-SHIFT: next cycle equals the reset values. The partial result is discarded and no done_valid is produced.
  - Input changes on x_in, y_in, sub_in, cin_in and cen_in after accept have no effect on the operation in flight.

Optional Feature:
- Macro: SERIAL_ALU_OVF_EN.
- Defined:
  - On the MSB cycle, ovf_out <= c_bit XOR carry_bit (carry into MSB vs carry out of MSB).
  - ovf_out is held through DONE and cleared on accept and on rst.
- Undefined: ovf_out is tied to 0 and no overflow logic is generated.

Test Plan:
All tests use WIDTH = 32, with the bench driving sum_bit/carry_bit from a behavioural full-adder model of the slice.
- Add: x = 0x00000005, y = 0x00000003, sub = 0, cin = 0, cen = 4'b0000 -> done_valid exactly 32 cycles after accept; result = 0x00000008, carry_out = 0, zero_out = 0.
- Subtract to zero: x = 0x0000000A, y = 0x0000000A, sub = 1 -> first c_bit = 1, all y_bit = ~y; result = 0x00000000, carry_out = 1, zero_out = 1.
- Wrap-around: x = 0xFFFFFFFF, y = 0x00000001, sub = 0 -> result = 0x00000000, carry_out = 1, zero_out = 1. With SERIAL_ALU_OVF_EN: ovf_out = 0. A second run with x = 0x7FFFFFFF, y = 0x00000001 -> ovf_out = 1, result = 0x80000000.
- Backpressure: hold done_ready = 0 for 10 cycles in DONE, pulsing start_valid -> start_ready stays 0, result is unchanged, no new operation starts. Raising done_ready -> IDLE next cycle, and the pending start is accepted the cycle after.
- Reset mid-operation: assert rst at SHIFT cycle 15 -> next cycle all outputs equal reset values, state = IDLE, and no done_valid appears afterwards.
- c_en hold: accept with cen_in = 4'b1011, then toggle cen_in every cycle -> c_en output stays 4'b1011 for all 32 SHIFT cycles and in DONE.
